dice_game_ctrl: RTL and testbench
=================================

# dice_game_ctrl

Two-player game controller that sequences and shares the electronic dice block. It grants the dice to the player whose turn it is and drives the dice's roll/button input. It captures the settled throw, accumulates per-player scores and alternates turns. It also declares a winner when a target score is reached.

## Interface

Parameters:
- MIN_ROLL, 4: minimum cycles `roll` stays high per throw (≥1).
- TARGET, 20: winning score (1..63).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- btn_a  input  1  player A roll button, synchronous, level.
- btn_b  input  1  player B roll button, synchronous, level.
- new_game  input  1  synchronous clear of game state, level.
- throw  input  3  current face from the dice block.
- roll  output  1  drives the dice button input; dice rolls while high.
- turn  output  1  current player: 0 = A, 1 = B.
- score_a  output  6  player A total.
- score_b  output  6  player B total.
- last_throw  output  3  most recent captured face (1..6).
- throw_valid  output  1  one-cycle pulse when a throw has been scored.
- winner_valid  output  1  high while in WIN.
- winner  output  1  winning player, meaningful when winner_valid = 1.

## Operation

- FSM states: IDLE, ROLL, SETTLE, CHECK, WIN. All outputs are registered or decoded from state only.
- Reset (rst_n low, asynchronous) forces the following:
  - state IDLE
  - roll 0, turn 0
  - score_a 0, score_b 0
  - last_throw 0
  - throw_valid 0, winner_valid 0, winner 0
  - roll counter 0
- IDLE:
  - The active button is btn_a when turn = 0 and btn_b when turn = 1. The other button is ignored.
  - Active button sampled high: go to ROLL and clear the roll counter.
- ROLL:
  - roll = 1; the counter increments each cycle and saturates at MIN_ROLL.
  - Exit to SETTLE when the active button is sampled low and counter+1 ≥ MIN_ROLL.
  - roll is therefore high for max(MIN_ROLL, press length) cycles.
- SETTLE:
  - roll = 0; lasts one cycle.
  - On the edge leaving SETTLE:
    - last_throw ← norm(throw).
    - The current player's score ← min(score + norm(throw), 63).
  - norm maps 0 and 7 to 1 and passes 1..6 unchanged.
- CHECK: lasts one cycle; throw_valid = 1. Next state:
  - Current player's score ≥ TARGET: go to WIN; winner ← turn.
  - Else if last_throw = 6: go to IDLE; turn unchanged (bonus roll).
  - Else: go to IDLE; turn toggles.
- WIN:
  - winner_valid = 1. Both buttons are ignored.
  - Scores and last_throw are held.
- new_game sampled high in any state:
  - Next edge loads all reset values. No score update occurs that cycle.
  - new_game has priority over all transitions.
  - A roll in progress is abandoned: roll drops on that edge.

## Timing

- Active press sampled at edge N (state IDLE):
  - roll = 1 from N through edge N+L, where L = max(MIN_ROLL, press length in cycles).
  - SETTLE runs for the following cycle.
  - Score and last_throw update at the end of SETTLE.
  - throw_valid is high for the single CHECK cycle after that.
  - turn and winner_valid change at the edge ending CHECK.
- Press to score latency: L+1 edges after roll rises.
- Minimum spacing between throws: a new press is accepted in the first IDLE cycle after CHECK. A button still held at that point starts the next roll immediately.
- throw is sampled only in SETTLE; its value in other states does not matter.
- Score saturation: 63 + x stays 63.
- Asynchronous reset mid-ROLL drops roll immediately, without waiting for a clock edge.

## Test plan

- Reset release followed by a 1-cycle btn_a pulse:
  - roll is high for exactly 4 cycles.
  - throw = 3 in SETTLE → score_a = 3, last_throw = 3, one throw_valid pulse, turn = 1.
- Turn arbitration:
  - With turn = 1, hold btn_a for 10 cycles → roll stays 0, no score change.
  - Then a btn_b press held 7 cycles → roll is high for 7 cycles.
- Bonus and normalisation:
  - Player A throws 6 → score_a += 6 and turn stays 0.
  - Next throw = 0 (invalid face) → last_throw = 1, score_a += 1, turn = 1.
- Win:
  - With score_a = 18 and turn = 0, throw 2 → score_a = 20, winner_valid = 1, winner = 0.
  - Subsequent btn_a/btn_b presses do not raise roll.
  - new_game → all outputs return to reset values next cycle.
- Mid-roll events:
  - rst_n asserted during ROLL → roll = 0 with no clock edge, scores = 0.
  - After reset release, new_game asserted during ROLL → roll = 0 next cycle and no throw_valid pulse.
- Saturation: with TARGET = 63, preload score_b = 60 via throws, then throw 6 → score_b = 63 and winner = 1.

Source files
------------

// File: rtl/dice_game_ctrl.sv
// Two-player dice game sequencer: grants the shared dice to the player whose
// turn it is, scores settled throws, alternates turns and declares a winner.
module dice_game_ctrl #(
    parameter int MIN_ROLL = 4,
    parameter int TARGET   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       new_game,
    input  logic [2:0] throw,
    output logic       roll,
    output logic       turn,
    output logic [5:0] score_a,
    output logic [5:0] score_b,
    output logic [2:0] last_throw,
    output logic       throw_valid,
    output logic       winner_valid,
    output logic       winner
);

    localparam int CW = $clog2(MIN_ROLL + 1);

    typedef enum logic [2:0] {IDLE, ROLL, SETTLE, CHECK, WIN} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          turn_reg, turn_next;
    logic [5:0]    score_a_reg, score_a_next;
    logic [5:0]    score_b_reg, score_b_next;
    logic [2:0]    last_reg, last_next;
    logic          winner_reg, winner_next;

    logic          active_btn;
    logic [5:0]    cur_score;
    logic [2:0]    face;
    logic [6:0]    sum;
    logic [5:0]    sat_score;

    assign active_btn = turn_reg ? btn_b : btn_a;
    assign cur_score  = turn_reg ? score_b_reg : score_a_reg;
    // Faces 0 and 7 are not real dice values; count them as a 1.
    assign face       = (throw == 3'd0 || throw == 3'd7) ? 3'd1 : throw;
    assign sum        = {1'b0, cur_score} + {4'b0000, face};
    assign sat_score  = (sum > 7'd63) ? 6'd63 : sum[5:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            turn_reg    <= 1'b0;
            score_a_reg <= 6'd0;
            score_b_reg <= 6'd0;
            last_reg    <= 3'd0;
            winner_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            turn_reg    <= turn_next;
            score_a_reg <= score_a_next;
            score_b_reg <= score_b_next;
            last_reg    <= last_next;
            winner_reg  <= winner_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        turn_next    = turn_reg;
        score_a_next = score_a_reg;
        score_b_next = score_b_reg;
        last_next    = last_reg;
        winner_next  = winner_reg;

        if (new_game) begin
            state_next   = IDLE;
            cnt_next     = '0;
            turn_next    = 1'b0;
            score_a_next = 6'd0;
            score_b_next = 6'd0;
            last_next    = 3'd0;
            winner_next  = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (active_btn) begin
                        state_next = ROLL;
                        cnt_next   = '0;
                    end
                end
                ROLL: begin
                    if (int'(cnt_reg) < MIN_ROLL) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                    if (!active_btn && (int'(cnt_reg) + 1 >= MIN_ROLL)) begin
                        state_next = SETTLE;
                    end
                end
                SETTLE: begin
                    last_next = face;
                    if (turn_reg) begin
                        score_b_next = sat_score;
                    end else begin
                        score_a_next = sat_score;
                    end
                    state_next = CHECK;
                end
                CHECK: begin
                    if (int'(cur_score) >= TARGET) begin
                        state_next  = WIN;
                        winner_next = turn_reg;
                    end else begin
                        state_next = IDLE;
                        // A six earns the same player another throw.
                        if (last_reg != 3'd6) begin
                            turn_next = ~turn_reg;
                        end
                    end
                end
                WIN: begin
                    state_next = WIN;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign roll         = (state_reg == ROLL);
    assign throw_valid  = (state_reg == CHECK);
    assign winner_valid = (state_reg == WIN);
    assign turn         = turn_reg;
    assign score_a      = score_a_reg;
    assign score_b      = score_b_reg;
    assign last_throw   = last_reg;
    assign winner       = winner_reg;

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Bench for dice_game_ctrl: two instances (TARGET 20 and 63) checked every
// cycle against a game-level model, plus directed literal checks.
module tb_dice_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_a_v [2];
    logic       btn_b_v [2];
    logic       ng_v    [2];
    logic [2:0] thr_v   [2];

    logic       roll_o [2];
    logic       turn_o [2];
    logic [5:0] sa_o   [2];
    logic [5:0] sb_o   [2];
    logic [2:0] last_o [2];
    logic       tv_o   [2];
    logic       wv_o   [2];
    logic       win_o  [2];

    always #5 clk = ~clk;

    dice_game_ctrl #(.MIN_ROLL(4), .TARGET(20)) u0 (
        .clk(clk), .rst_n(rst_n), .btn_a(btn_a_v[0]), .btn_b(btn_b_v[0]),
        .new_game(ng_v[0]), .throw(thr_v[0]), .roll(roll_o[0]), .turn(turn_o[0]),
        .score_a(sa_o[0]), .score_b(sb_o[0]), .last_throw(last_o[0]),
        .throw_valid(tv_o[0]), .winner_valid(wv_o[0]), .winner(win_o[0])
    );

    dice_game_ctrl #(.MIN_ROLL(4), .TARGET(63)) u1 (
        .clk(clk), .rst_n(rst_n), .btn_a(btn_a_v[1]), .btn_b(btn_b_v[1]),
        .new_game(ng_v[1]), .throw(thr_v[1]), .roll(roll_o[1]), .turn(turn_o[1]),
        .score_a(sa_o[1]), .score_b(sb_o[1]), .last_throw(last_o[1]),
        .throw_valid(tv_o[1]), .winner_valid(wv_o[1]), .winner(win_o[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int k, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[u%0d] got=%0d expected=%0d at %0t", name, k, act, exp, $time);
        end
    endtask

    // Game-level model: phase 0 waiting, 1 rolling, 2 settling, 3 scored, 4 won.
    int m_phase  [2];
    int m_rolled [2];
    int m_turn   [2];
    int m_score  [2][2];
    int m_last   [2];
    int m_winner [2];
    int tgt      [2] = '{20, 63};

    task automatic m_reset(input int k);
        m_phase[k] = 0; m_rolled[k] = 0; m_turn[k] = 0;
        m_score[k][0] = 0; m_score[k][1] = 0; m_last[k] = 0; m_winner[k] = 0;
    endtask

    always @(negedge rst_n) begin
        m_reset(0);
        m_reset(1);
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int held, f, p;
            held = (m_turn[k] == 1) ? int'(btn_b_v[k]) : int'(btn_a_v[k]);
            p = m_turn[k];
            if (!rst_n || ng_v[k]) begin
                m_reset(k);
            end else if (m_phase[k] == 0) begin
                if (held == 1) begin m_phase[k] = 1; m_rolled[k] = 0; end
            end else if (m_phase[k] == 1) begin
                m_rolled[k]++;
                if (held == 0 && m_rolled[k] >= 4) m_phase[k] = 2;
            end else if (m_phase[k] == 2) begin
                f = int'(thr_v[k]);
                if (f == 0 || f == 7) f = 1;
                m_last[k] = f;
                m_score[k][p] = (m_score[k][p] + f > 63) ? 63 : m_score[k][p] + f;
                m_phase[k] = 3;
            end else if (m_phase[k] == 3) begin
                if (m_score[k][p] >= tgt[k]) begin
                    m_phase[k] = 4; m_winner[k] = p;
                end else begin
                    m_phase[k] = 0;
                    if (m_last[k] != 6) m_turn[k] = 1 - p;
                end
            end
        end
    end

    bit chk_en = 1'b0;
    int rc  [2] = '{0, 0};
    int tvc [2] = '{0, 0};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (roll_o[k] === 1'b1) rc[k]++;
            if (tv_o[k] === 1'b1) tvc[k]++;
            if (chk_en) begin
                chk("roll", k, int'(roll_o[k]), int'(m_phase[k] == 1));
                chk("throw_valid", k, int'(tv_o[k]), int'(m_phase[k] == 3));
                chk("winner_valid", k, int'(wv_o[k]), int'(m_phase[k] == 4));
                chk("turn", k, int'(turn_o[k]), m_turn[k]);
                chk("score_a", k, int'(sa_o[k]), m_score[k][0]);
                chk("score_b", k, int'(sb_o[k]), m_score[k][1]);
                chk("last_throw", k, int'(last_o[k]), m_last[k]);
                chk("winner", k, int'(win_o[k]), m_winner[k]);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Press for len edges with the given face held on throw, then wait
    // until the scored cycle has passed.
    task automatic do_throw(input int k, input bit b, input int len, input logic [2:0] face);
        bit got;
        thr_v[k] = face;
        if (b) btn_b_v[k] = 1'b1; else btn_a_v[k] = 1'b1;
        repeat (len) step();
        btn_a_v[k] = 1'b0;
        btn_b_v[k] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tv_o[k]) begin got = 1'b1; break; end
            step();
        end
        chk("scored_in_time", k, int'(got), 1);
        step();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            btn_a_v[k] = 1'b0; btn_b_v[k] = 1'b0; ng_v[k] = 1'b0; thr_v[k] = 3'd0;
        end
        m_reset(0);
        m_reset(1);
        repeat (3) step();
        rst_n = 1'b1;
        chk_en = 1'b1;
        step();
        chk("reset_score_a", 0, int'(sa_o[0]), 0);
        chk("reset_roll", 0, int'(roll_o[0]), 0);
        chk("reset_turn", 0, int'(turn_o[0]), 0);

        // Single-cycle press gives a minimum-length roll.
        rc[0] = 0; tvc[0] = 0;
        do_throw(0, 1'b0, 1, 3'd3);
        chk("min_roll_len", 0, rc[0], 4);
        chk("tv_pulses", 0, tvc[0], 1);
        chk("first_score_a", 0, int'(sa_o[0]), 3);
        chk("first_last", 0, int'(last_o[0]), 3);
        chk("first_turn", 0, int'(turn_o[0]), 1);

        // Inactive player's button is ignored.
        rc[0] = 0;
        btn_a_v[0] = 1'b1;
        repeat (10) step();
        btn_a_v[0] = 1'b0;
        step();
        chk("wrong_btn_roll", 0, rc[0], 0);
        chk("wrong_btn_score", 0, int'(sa_o[0]), 3);

        rc[0] = 0;
        do_throw(0, 1'b1, 7, 3'd2);
        chk("long_roll_len", 0, rc[0], 7);
        chk("b_score", 0, int'(sb_o[0]), 2);

        // Bonus on six, then an invalid face counts as one.
        do_throw(0, 1'b0, 1, 3'd6);
        chk("six_score", 0, int'(sa_o[0]), 9);
        chk("six_bonus_turn", 0, int'(turn_o[0]), 0);
        do_throw(0, 1'b0, 2, 3'd0);
        chk("norm_last", 0, int'(last_o[0]), 1);
        chk("norm_score", 0, int'(sa_o[0]), 10);
        chk("norm_turn", 0, int'(turn_o[0]), 1);

        // Bring A to 18, then the winning throw.
        do_throw(0, 1'b1, 1, 3'd1);
        do_throw(0, 1'b0, 1, 3'd6);
        do_throw(0, 1'b0, 1, 3'd2);
        do_throw(0, 1'b1, 1, 3'd1);
        chk("pre_win_score", 0, int'(sa_o[0]), 18);
        do_throw(0, 1'b0, 1, 3'd2);
        chk("win_score", 0, int'(sa_o[0]), 20);
        chk("win_valid", 0, int'(wv_o[0]), 1);
        chk("win_who", 0, int'(win_o[0]), 0);
        rc[0] = 0;
        btn_a_v[0] = 1'b1; repeat (3) step(); btn_a_v[0] = 1'b0;
        btn_b_v[0] = 1'b1; repeat (3) step(); btn_b_v[0] = 1'b0;
        step();
        chk("win_locked", 0, rc[0], 0);
        ng_v[0] = 1'b1; step(); ng_v[0] = 1'b0;
        chk("ng_score_a", 0, int'(sa_o[0]), 0);
        chk("ng_wv", 0, int'(wv_o[0]), 0);
        chk("ng_last", 0, int'(last_o[0]), 0);

        // Asynchronous reset in the middle of a roll.
        do_throw(0, 1'b0, 1, 3'd5);
        btn_b_v[0] = 1'b1;
        step(); step();
        chk("pre_rst_roll", 0, int'(roll_o[0]), 1);
        rst_n = 1'b0;
        #2;
        chk("async_rst_roll", 0, int'(roll_o[0]), 0);
        chk("async_rst_score", 0, int'(sa_o[0]), 0);
        btn_b_v[0] = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // new_game abandons a roll without scoring.
        btn_a_v[0] = 1'b1;
        step(); step();
        tvc[0] = 0;
        ng_v[0] = 1'b1; step(); ng_v[0] = 1'b0; btn_a_v[0] = 1'b0;
        chk("ng_roll_drop", 0, int'(roll_o[0]), 0);
        repeat (10) step();
        chk("ng_no_tv", 0, tvc[0], 0);

        // Saturation on the TARGET=63 instance.
        do_throw(1, 1'b0, 1, 3'd1);
        for (int i = 0; i < 10; i++) do_throw(1, 1'b1, 1, 3'd6);
        chk("sat_pre", 1, int'(sb_o[1]), 60);
        do_throw(1, 1'b1, 2, 3'd6);
        chk("sat_score", 1, int'(sb_o[1]), 63);
        chk("sat_wv", 1, int'(wv_o[1]), 1);
        chk("sat_winner", 1, int'(win_o[1]), 1);

        // Random play on both instances.
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 3) == 0) btn_a_v[k] = ~btn_a_v[k];
                if ($urandom_range(0, 3) == 0) btn_b_v[k] = ~btn_b_v[k];
                ng_v[k]  = ($urandom_range(0, 149) == 0);
                thr_v[k] = 3'($urandom_range(0, 7));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
